// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU front end: widths, opcodes, instruction
// field layout, issue-controller FSM encoding and result error codes.
// Used by the issue controller, the register file, the ALU and the fetch stage.
package cpu_pkg;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned IMM_W  = 11;
    localparam int unsigned ERR_W  = 2;

    // Opcodes 0..10 go to the ALU, 11 is load-immediate, 12..31 are illegal.
    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;
    localparam logic [OP_W-1:0] OP_MUL = 5'd2;
    localparam logic [OP_W-1:0] OP_DIV = 5'd3;
    localparam logic [OP_W-1:0] OP_INC = 5'd4;
    localparam logic [OP_W-1:0] OP_DEC = 5'd5;
    localparam logic [OP_W-1:0] OP_AND = 5'd6;
    localparam logic [OP_W-1:0] OP_OR  = 5'd7;
    localparam logic [OP_W-1:0] OP_XOR = 5'd8;
    localparam logic [OP_W-1:0] OP_LSL = 5'd9;
    localparam logic [OP_W-1:0] OP_LSR = 5'd10;
    localparam logic [OP_W-1:0] OP_LDI = 5'd11;

    localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [ERR_W-1:0] ERR_DIV0    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Instruction word layout; the LDI immediate overlays rs1/rs2/tail.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [4:0]        tail;
    } instr_t;

    function automatic logic [IMM_W-1:0] instr_imm(instr_t i);
        return {i.rs1, i.rs2, i.tail};
    endfunction

    function automatic logic is_alu_op(logic [OP_W-1:0] op);
        return op <= OP_LSR;
    endfunction

endpackage

// File: rtl/cpu_regfile_8x19.sv
// 8 x 19 register file: two combinational read ports, one synchronous write
// port, r0 hardwired to zero, asynchronous active-low clear of every entry.
// Ports: clk, rst_n; raddr_a/rdata_a_c, raddr_b/rdata_b_c (read);
//        we, waddr, wdata (write, applied at the rising edge).
module cpu_regfile_8x19
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a_c,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b_c,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] mem [NREGS];

    // Storage; entry 0 is never written so it stays at its cleared value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // r0 decoded to zero explicitly so the read path never depends on mem[0].
    assign rdata_a_c = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b_c = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational 19-bit ALU. Accepts one
// instruction at a time, reads operands from the register file, drives the ALU
// for a single cycle, writes the result back and presents it on a result port.
// Ports: clk, rst_n; instr_valid/instr_ready/instr (instruction in);
//        alu_a/alu_b/alu_op (to ALU), alu_result/alu_zero (from ALU);
//        res_valid/res_ready/res_data/res_zero/res_rd/res_err (result out);
//        busy (controller not idle).
module alu_issue_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic [REG_AW-1:0] res_rd,
    output logic [ERR_W-1:0]  res_err,
    output logic              busy
);

    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic [REG_AW-1:0] res_rd_q, res_rd_d;
    logic [ERR_W-1:0]  res_err_q, res_err_d;
    logic              instr_ready_q, instr_ready_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] rf_a_c;
    logic [DATA_W-1:0] rf_b_c;
    logic              rf_we_c;
    logic [DATA_W-1:0] rf_wdata_c;

    cpu_regfile_8x19 u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (instr_q.rs1),
        .rdata_a_c (rf_a_c),
        .raddr_b   (instr_q.rs2),
        .rdata_b_c (rf_b_c),
        .we        (rf_we_c),
        .waddr     (instr_q.rd),
        .wdata     (rf_wdata_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= OP_ADD;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_zero_q    <= 1'b0;
            res_rd_q      <= '0;
            res_err_q     <= ERR_OK;
            instr_ready_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_zero_q    <= res_zero_d;
            res_rd_q      <= res_rd_d;
            res_err_q     <= res_err_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
        end
    end

    // Next-state, datapath and writeback control.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_rd_d    = res_rd_q;
        res_err_d   = res_err_q;
        rf_we_c     = 1'b0;
        rf_wdata_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    instr_d = instr_t'(instr);
                    state_d = ST_DECODE;
                end
            end

            // Operands are loaded straight into the ALU drive registers so
            // they appear on alu_a/alu_b for exactly the EXEC cycle.
            ST_DECODE: begin
                if (is_alu_op(instr_q.op)) begin
                    alu_a_d  = rf_a_c;
                    alu_b_d  = rf_b_c;
                    alu_op_d = instr_q.op;
                end
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                res_rd_d = instr_q.rd;
                if (is_alu_op(instr_q.op)) begin
                    if ((instr_q.op == OP_DIV) && (alu_b_q == '0)) begin
                        res_data_d = '0;
                        res_zero_d = 1'b1;
                        res_err_d  = ERR_DIV0;
                    end else begin
                        res_data_d = alu_result;
                        res_zero_d = alu_zero;
                        res_err_d  = ERR_OK;
                    end
                end else if (instr_q.op == OP_LDI) begin
                    res_data_d = DATA_W'(instr_imm(instr_q));
                    res_zero_d = (instr_imm(instr_q) == '0);
                    res_err_d  = ERR_OK;
                end else begin
                    res_data_d = '0;
                    res_zero_d = 1'b1;
                    res_err_d  = ERR_ILLEGAL;
                end
                rf_we_c    = (res_err_d == ERR_OK) && (instr_q.rd != '0);
                rf_wdata_c = res_data_d;
                alu_a_d    = '0;
                alu_b_d    = '0;
                alu_op_d   = OP_ADD;
                state_d    = ST_RESP;
            end

            // First RESP cycle raises res_valid; the handshake only counts
            // once res_valid is already visible to the consumer.
            ST_RESP: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instr_ready_d = (state_d == ST_IDLE);
    assign busy_d        = (state_d != ST_IDLE);

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_rd      = res_rd_q;
    assign res_err     = res_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stub, golden register-file model, scoreboard.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [18:0] instr;
    logic [18:0] alu_a;
    logic [18:0] alu_b;
    logic [4:0]  alu_op;
    logic [18:0] alu_result;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [18:0] res_data;
    logic        res_zero;
    logic [2:0]  res_rd;
    logic [1:0]  res_err;
    logic        busy;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .res_rd      (res_rd),
        .res_err     (res_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] data;
        logic        zero;
        logic [2:0]  rd;
        logic [1:0]  err;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_q[$];
    logic [18:0] rf_m [8];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rr_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit          seen    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic ALU behaviour, 19-bit truncation.
    function automatic logic [18:0] alu_fn(logic [4:0] op, logic [18:0] a, logic [18:0] b);
        logic [63:0] w;
        case (op)
            5'd0:  w = 64'(a) + 64'(b);
            5'd1:  w = 64'(a) - 64'(b);
            5'd2:  w = 64'(a) * 64'(b);
            5'd3:  w = (b == 0) ? 64'd0 : 64'(a) / 64'(b);
            5'd4:  w = 64'(a) + 64'd1;
            5'd5:  w = 64'(a) - 64'd1;
            5'd6:  w = 64'(a & b);
            5'd7:  w = 64'(a | b);
            5'd8:  w = 64'(a ^ b);
            5'd9:  w = (b >= 19) ? 64'd0 : (64'(a) << b);
            5'd10: w = (b >= 19) ? 64'd0 : (64'(a) >> b);
            default: w = 64'd0;
        endcase
        return w[18:0];
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result == 19'd0);
    end

    function automatic logic [18:0] mk(int op, int rd, int rs1, int rs2);
        return {5'(op), 3'(rd), 3'(rs1), 3'(rs2), 5'd0};
    endfunction

    function automatic logic [18:0] mki(int rd, int imm);
        return {5'd11, 3'(rd), 11'(imm)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Golden model: executes one instruction against rf_m and queues the response.
    task automatic model_exec(input logic [18:0] w);
        exp_t        e;
        int          op, rd, rs1, rs2;
        logic [18:0] a, b;
        op  = int'(w[18:14]);
        rd  = int'(w[13:11]);
        rs1 = int'(w[10:8]);
        rs2 = int'(w[7:5]);
        a   = (rs1 == 0) ? 19'd0 : rf_m[rs1];
        b   = (rs2 == 0) ? 19'd0 : rf_m[rs2];
        e.rd = 3'(rd);
        if (op <= 10) begin
            if (op == 3 && b == 0) begin
                e.data = 0; e.zero = 1; e.err = 2'b10;
            end else begin
                e.data = alu_fn(5'(op), a, b);
                e.zero = (e.data == 0);
                e.err  = 2'b00;
            end
        end else if (op == 11) begin
            e.data = {8'd0, w[10:0]};
            e.zero = (w[10:0] == 11'd0);
            e.err  = 2'b00;
        end else begin
            e.data = 0; e.zero = 1; e.err = 2'b01;
        end
        if (e.err == 2'b00 && rd != 0) rf_m[rd] = e.data;
        exp_q.push_back(e);
    endtask

    // Offer one instruction (called at a negedge); returns at the negedge after acceptance.
    task automatic issue(input logic [18:0] w, input bit push);
        int k;
        if (push) model_exec(w);
        instr       = w;
        instr_valid = 1'b1;
        for (k = 0; k < 400; k++) begin
            if (instr_ready) break;
            @(negedge clk);
        end
        if (k == 400) begin
            fail_now("issue_accept");
            instr_valid = 1'b0;
            if (push) void'(exp_q.pop_back());
            return;
        end
        check("alu_idle", {8'd0, alu_a ^ alu_b, alu_op}, 32'd0);
        check("alu_idle_a", {13'd0, alu_a}, 32'd0);
        @(posedge clk);
        #1;
        if (push) acc_q.push_back(cyc);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && !res_valid) break;
            @(negedge clk);
        end
        if (k == 3000) fail_now("drain");
    endtask

    // Consumer-side ready generator, changing well away from both clock edges.
    always begin
        @(posedge clk);
        #2;
        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = ($urandom_range(0, 3) != 0);
            default: res_ready = 1'b0;
        endcase
    end

    // Monitor: compares each response once, on the first cycle res_valid is seen.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            seen = 0;
        end else if (res_valid && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: res_data 0x%0h with no expected entry", res_data);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("res_data", {13'd0, res_data}, {13'd0, e.data});
                check("res_zero", {31'd0, res_zero}, {31'd0, e.zero});
                check("res_rd",   {29'd0, res_rd},   {29'd0, e.rd});
                check("res_err",  {30'd0, res_err},  {30'd0, e.err});
                check("latency",  cyc - a, 32'd3);
            end
        end else if (!res_valid) begin
            seen = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] snap;
        int          k;
        for (int i = 0; i < 8; i++) rf_m[i] = 19'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        res_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {instr_ready, busy, res_valid, res_zero, res_err, res_rd},
              32'd0);
        check("rst_data", {13'd0, res_data}, 32'd0);
        check("rst_alu", {8'd0, alu_a | alu_b, alu_op}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        // Directed: loads, add, wrap-around, truncation, divide, illegal, r0 writes.
        issue(mki(1, 5), 1);
        issue(mki(2, 3), 1);
        issue(mk(0, 3, 1, 2), 1);
        issue(mk(1, 4, 2, 1), 1);
        issue(mk(5, 5, 0, 0), 1);
        issue(mki(6, 400), 1);
        issue(mk(2, 7, 6, 6), 1);
        issue(mki(6, 1000), 1);
        issue(mk(2, 7, 6, 6), 1);
        issue(mki(6, 0), 1);
        issue(mk(3, 6, 1, 0), 1);
        issue(mk(0, 7, 6, 0), 1);
        issue(mk(3, 6, 1, 2), 1);
        issue(mk(20, 2, 1, 1), 1);
        issue(mk(0, 7, 2, 0), 1);
        issue(mki(0, 9), 1);
        issue(mk(0, 1, 0, 0), 1);
        issue(mki(1, 5), 1);
        issue(mki(2, 21), 1);
        issue(mk(9, 3, 1, 2), 1);
        issue(mki(2, 2), 1);
        issue(mk(9, 3, 1, 2), 1);
        issue(mk(10, 4, 3, 2), 1);
        drain();

        // Backpressure: result held, new instruction offered and ignored.
        rr_mode = 2;
        @(negedge clk);
        @(negedge clk);
        issue(mk(1, 4, 2, 1), 1);
        for (k = 0; k < 50; k++) begin
            if (res_valid) break;
            @(negedge clk);
        end
        if (k == 50) fail_now("hold_wait_valid");
        snap = {res_valid, res_data, res_zero, res_rd, res_err, 1'b0};
        instr       = mk(0, 7, 1, 1);
        instr_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("hold_stable", {5'd0, res_valid, res_data, res_zero, res_rd, res_err, instr_ready},
                  {5'd0, snap});
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        instr_valid = 1'b0;
        rr_mode     = 0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (res_ready && res_valid) break;
        end
        if (k == 10) fail_now("hold_release");
        @(negedge clk);
        check("idle_after_hs", {29'd0, busy, instr_ready, res_valid}, 32'b010);
        drain();

        // Reset during EXEC: no response, register file cleared.
        issue(mki(1, 7), 1);
        issue(mki(2, 9), 1);
        drain();
        issue(mk(0, 3, 1, 2), 0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) rf_m[i] = 19'd0;
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_quiet", {30'd0, res_valid, instr_ready}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {30'd0, instr_ready, res_valid}, 32'b10);
        issue(mk(0, 4, 3, 0), 1);
        issue(mk(0, 5, 1, 2), 1);
        drain();

        // Random traffic with random consumer backpressure.
        rr_mode = 1;
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [18:0] w;
            r = int'($urandom_range(0, 99));
            if (r < 25)
                w = mki(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)));
            else if (r < 90)
                w = mk(int'($urandom_range(0, 10)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else
                w = mk(int'($urandom_range(12, 31)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            issue(w, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rr_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
